// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the RISC core data memory controller.
package risc_mem_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam int BYTE_W    = 8;
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage with per-byte write enables and combinational read.
// Out-of-range addresses neither write nor return stored data.
module data_mem_array
    import risc_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clka,
    input  logic                     we,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NBYTES = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = 32'(addr) < DEPTH;

    always_ff @(posedge clka) begin
        if (we && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = in_range ? mem[addr] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the RISC MEM stage: req/ready/ack handshake with
// programmable latency, byte-enable writes, range check and post-reset clear sweep.
//
// state   | meaning
// ST_INIT | zeroing word clr_addr, one word per cycle
// ST_IDLE | waiting for a request
// ST_BUSY | latency countdown; access performed when lat_cnt reaches 0
module data_mem_ctrl
    import risc_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int LATENCY  = 1,
    parameter int CLEAR_EN = 1
) (
    input  logic                     clka,
    input  logic                     rsta_n,
    input  logic                     req_a,
    input  logic                     wea,
    input  logic [DATA_W/BYTE_W-1:0] bea,
    input  logic [ADDR_W-1:0]        addra,
    input  logic [DATA_W-1:0]        dina,
    output logic                     ready_a,
    output logic                     ack_a,
    output logic                     err_a,
    output logic [DATA_W-1:0]        douta
);

    localparam int                   NBYTES    = DATA_W / BYTE_W;
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE   = LAT_CNT_W'(1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam state_t               RST_STATE = (CLEAR_EN != 0) ? ST_INIT : ST_IDLE;

    state_t               state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [ADDR_W-1:0]    clr_addr;
    logic                 we_q;
    logic [NBYTES-1:0]    be_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    din_q;
    logic                 ready_q;

    logic                 accept;
    logic                 done;
    logic                 q_in_range;
    logic                 arr_we;
    logic [NBYTES-1:0]    arr_be;
    logic [ADDR_W-1:0]    arr_addr;
    logic [DATA_W-1:0]    arr_wdata;
    logic [DATA_W-1:0]    arr_rdata;

    // ready_q is only set in IDLE or on the last BUSY cycle, so a new request
    // can be accepted on the same edge that completes the previous one.
    assign accept     = req_a && ready_q;
    assign done       = (state == ST_BUSY) && (lat_cnt == '0);
    assign q_in_range = 32'(addr_q) < DEPTH;
    assign ready_a    = ready_q;

    always_comb begin
        arr_we    = 1'b0;
        arr_be    = '1;
        arr_addr  = addr_q;
        arr_wdata = '0;
        if (state == ST_INIT) begin
            arr_we   = 1'b1;
            arr_addr = clr_addr;
        end else if (done && we_q && q_in_range) begin
            arr_we    = 1'b1;
            arr_be    = be_q;
            arr_wdata = din_q;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clka   (clka),
        .we     (arr_we),
        .be     (arr_be),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .rdata  (arr_rdata)
    );

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state    <= RST_STATE;
            lat_cnt  <= '0;
            clr_addr <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            ready_q  <= 1'b0;
            ack_a    <= 1'b0;
            err_a    <= 1'b0;
            douta    <= '0;
        end else begin
            ack_a <= 1'b0;
            err_a <= 1'b0;
            case (state)
                ST_INIT: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    // also covers the first cycle after reset when the sweep is skipped
                    ready_q <= 1'b1;
                end
                ST_BUSY: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                        ready_q <= (lat_cnt == LAT_ONE);
                    end else begin
                        ack_a   <= 1'b1;
                        err_a   <= !q_in_range;
                        if (!we_q) begin
                            douta <= arr_rdata;
                        end
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= RST_STATE;
                    ready_q <= 1'b0;
                end
            endcase
            if (accept) begin
                we_q    <= wea;
                be_q    <= bea;
                addr_q  <= addra;
                din_q   <= dina;
                lat_cnt <= LAT_LOAD;
                state   <= ST_BUSY;
                ready_q <= (LAT_LOAD == '0);
            end
        end
    end

endmodule
